// File: rtl/div_unit_param.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU, one quotient bit per cycle,
// with optional leading-zero skip and single-cycle divide-by-zero / signed-overflow paths.
module div_unit_param #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [WIDTH-1:0]      dividend_i,
  input  logic [WIDTH-1:0]      divisor_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  output logic [WIDTH-1:0]      result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op;
  logic [WIDTH-1:0] dvd, dvs, rem, quo;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;

  logic             is_signed, is_div, dvd_neg, dvs_neg, div_zero, ovf;
  logic [WIDTH-1:0] dvd_abs, dvs_abs, dvd_pre, diff, q_fin, r_fin;
  logic [CW-1:0]    lz, n_iter;
  logic [WIDTH:0]   trial;
  logic             q_bit;

  always_comb begin
    // funct3[2] is set for every M-extension divide; signed variants have funct3[0]=0
    is_signed = op[2] & ~op[0];
    is_div    = ~op[1];
    dvd_neg   = is_signed & dvd[WIDTH-1];
    dvs_neg   = is_signed & dvs[WIDTH-1];
    div_zero  = (dvs == '0);
    ovf       = is_signed & (dvd == {1'b1, {(WIDTH-1){1'b0}}}) & (dvs == '1);
    dvd_abs   = dvd_neg ? -dvd : dvd;
    dvs_abs   = dvs_neg ? -dvs : dvs;
    // ascending scan: the last hit is the most significant set bit
    lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (dvd_abs[i]) lz = CW'(WIDTH - 1 - i);
    n_iter  = EARLY_TERM ? CW'(WIDTH) - lz : CW'(WIDTH);
    dvd_pre = EARLY_TERM ? dvd_abs << lz : dvd_abs;
    trial   = {rem, dvd[WIDTH-1]};
    q_bit   = (trial >= {1'b0, dvs});
    diff    = trial[WIDTH-1:0] - dvs;
    q_fin   = neg_q ? -quo : quo;
    r_fin   = neg_r ? -rem : rem;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_i && !ready_o) state_nxt = S_START;
      S_START: begin
        if (!start_i || div_zero || ovf) state_nxt = S_IDLE;
        else if (n_iter == '0)           state_nxt = S_END;
        else                             state_nxt = S_CALC;
      end
      S_CALC: begin
        if (!start_i)              state_nxt = S_IDLE;
        else if (cnt == CW'(1))    state_nxt = S_END;
      end
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op          <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      result_o    <= '0;
      ready_o     <= 1'b0;
      busy_o      <= 1'b0;
      reg_waddr_o <= '0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        S_IDLE: if (start_i && !ready_o) begin
          op          <= op_i;
          dvd         <= dividend_i;
          dvs         <= divisor_i;
          reg_waddr_o <= reg_waddr_i;
          busy_o      <= 1'b1;
        end
        S_START: begin
          if (!start_i) busy_o <= 1'b0;
          else if (div_zero) begin
            result_o <= is_div ? '1 : dvd;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
          end else if (ovf) begin
            result_o <= is_div ? dvd : '0;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
          end else begin
            dvd   <= dvd_pre;
            dvs   <= dvs_abs;
            rem   <= '0;
            quo   <= '0;
            cnt   <= n_iter;
            neg_q <= dvd_neg ^ dvs_neg;
            neg_r <= dvd_neg;
          end
        end
        S_CALC: begin
          if (!start_i) busy_o <= 1'b0;
          else begin
            rem <= q_bit ? diff : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], q_bit};
            dvd <= dvd << 1;
            cnt <= cnt - CW'(1);
          end
        end
        S_END: begin
          if (!start_i) busy_o <= 1'b0;
          else begin
            result_o <= is_div ? q_fin : r_fin;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
          end
        end
        default: busy_o <= 1'b0;
      endcase
    end
  end

endmodule
